priority_encoder_rr: RTL and testbench
======================================

// Module: priority_encoder_rr
// PURPOSE
//  Registered, handshaked successor of the one-hot encoder. Accepts an N-bit request vector and
//  returns the index of the winning set bit, using LSB-first, MSB-first or round-robin priority.
//  Also flags the zero-vector and multi-hot cases. Sits between request sources and a downstream
//  consumer, with valid/ready on both sides.
// PARAMETERS
//  N     64          request vector width, N >= 2; N need not be a power of two
//  W     $clog2(N)   index width (derived localparam, not overridable)
// PORTS
//  clk        in   1   clock; all state updates on the rising edge
//  rst_n      in   1   reset, synchronous, active-low
//  enable     in   1   global enable; 0 blocks new acceptance
//  in_valid   in   1   request vector a is valid
//  in_ready   out  1   block can accept a this cycle
//  a          in   N   request vector
//  mode       in   2   00 LSB-first, 01 MSB-first, 10 round-robin, 11 reserved (acts as 00)
//  out_valid  out  1   y/found/multi valid
//  out_ready  in   1   consumer takes output this cycle
//  y          out  W   winning bit index
//  found      out  1   a had at least one set bit
//  multi      out  1   a had two or more set bits
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): out_valid=0, y=0, found=0, multi=0, rr_ptr=0. in_ready=0 during
//    reset. Reset mid-transfer discards any pending output.
//  - in_ready = enable & (~out_valid | out_ready), combinational. Single output register, no skid.
//  - Accept when in_valid & in_ready. At that edge: y/found/multi load from a and mode, and
//    out_valid=1. Latency is exactly 1 cycle from acceptance to out_valid.
//  - Output holds stable while out_valid & ~out_ready.
//  - out_valid clears on out_valid & out_ready & ~accept. Same-edge drain + accept: new result loads
//    and out_valid stays 1 (full throughput, 1 vector/cycle).
//  - enable=0 does not clear out_valid; a pending result still drains.
//  - mode is sampled only at acceptance; changing it while out_valid is held has no effect.
//  - LSB-first: y = lowest set index. MSB-first: y = highest set index.
//  - Round-robin: y = first set index at or above rr_ptr, searching upward and wrapping N-1 -> 0.
//    On accept with found=1, rr_ptr <= (y==N-1) ? 0 : y+1. The wrap is at N, not 2**W.
//  - rr_ptr updates only on round-robin accepts; LSB-first and MSB-first accepts leave it unchanged.
//  - Zero vector: found=0, multi=0, y=0, out_valid=1 (the result is still delivered); rr_ptr unchanged.
//  - multi = (a & (a-1)) != 0, independent of mode.
//  - y is always < N.
//  - No X propagation: a containing X/Z is not a legal input; the bench does not drive it.
// TESTING
//  T1 reset: rst_n=0 for 2 clks with in_valid=1 -> out_valid=0, y=0, in_ready=0; rr_ptr=0 after release.
//  T2 one-hot sweep, N=64, mode=00: a=1<<i for i=0..63, out_ready=1 -> y=i 1 clk later, found=1,
//     multi=0, one result per clk.
//  T3 priority: a=64'h8000_0000_0000_0011 -> mode 00 y=0; mode 01 y=63; multi=1 in both.
//  T4 round-robin: a=64'h8000_0000_0000_0011 accepted 4x, mode 10 -> y=0,4,63,0 (rr_ptr wraps 63->0);
//     then a=0 -> found=0, y=0, next y for 64'h11 is 4.
//  T5 backpressure: out_ready=0 for 3 clks after a result -> y stable, in_ready=0; raise out_ready with
//     in_valid=1 -> drain and accept on the same edge, out_valid stays 1.
//  T6 N=5 (W=3), mode 10: a=5'b10001 accepted 3x -> y=0,4,0; y never reaches 5..7; enable=0 -> in_ready=0,
//     pending output still drains.

Source files
------------

// File: rtl/priority_encoder_rr_if.sv
// Handshake bundle for priority_encoder_rr: a request side carrying the
// vector and priority mode, and a result side carrying the winning index
// and its flags. Both sides use valid/ready.
interface priority_encoder_rr_if #(
  parameter int N = 64
);
  localparam int W = $clog2(N);

  logic         enable;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [1:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         found;
  logic         multi;

  // Request source and result consumer side
  modport master (
    output enable, in_valid, a, mode, out_ready,
    input  in_ready, out_valid, y, found, multi
  );

  // Encoder side
  modport slave (
    input  enable, in_valid, a, mode, out_ready,
    output in_ready, out_valid, y, found, multi
  );
endinterface

// File: rtl/priority_encoder_rr.sv
// Registered priority encoder with valid/ready on both sides. Picks the
// winning set bit of a request vector using LSB-first, MSB-first or
// round-robin priority, and flags empty and multi-hot vectors. A single
// output register gives one-cycle latency and full throughput when the
// consumer keeps up.
module priority_encoder_rr #(
  parameter int N = 64
) (
  input logic                 clk,
  input logic                 rst_n,
  priority_encoder_rr_if.slave bus
);
  localparam int W = $clog2(N);

  logic [W-1:0] lsb_idx;
  logic [W-1:0] msb_idx;
  logic [W-1:0] rr_idx;
  logic         rr_hit;
  logic [W-1:0] win_idx;
  logic [W-1:0] ptr_next;
  logic         any_set;
  logic         many_set;
  logic         accept;

  logic         result_valid;
  logic [W-1:0] result_y;
  logic         result_found;
  logic         result_multi;
  logic [W-1:0] rr_ptr;

  // The block only takes a new vector when enabled, out of reset, and the
  // output register is either empty or being emptied on this same edge.
  assign bus.in_ready = rst_n & bus.enable & (~result_valid | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;

  assign bus.out_valid = result_valid;
  assign bus.y         = result_y;
  assign bus.found     = result_found;
  assign bus.multi     = result_multi;

  // Lowest set index: scan downward so the last hit is the lowest bit.
  always_comb begin
    lsb_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.a[i]) lsb_idx = W'(i);
    end
  end

  // Highest set index: scan upward so the last hit is the highest bit.
  always_comb begin
    msb_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.a[i]) msb_idx = W'(i);
    end
  end

  // Round-robin: lowest set bit at or above the pointer, otherwise wrap to the lowest set bit overall.
  always_comb begin
    rr_idx = '0;
    rr_hit = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.a[i] && (i >= int'(rr_ptr))) begin
        rr_idx = W'(i);
        rr_hit = 1'b1;
      end
    end
    if (!rr_hit) rr_idx = lsb_idx;
  end

  // Mode select, presence flags and the pointer advance; the pointer wraps at N, not at 2**W.
  always_comb begin
    any_set  = |bus.a;
    many_set = |(bus.a & (bus.a - {{(N - 1){1'b0}}, 1'b1}));
    case (bus.mode)
      2'b01:   win_idx = msb_idx;
      2'b10:   win_idx = rr_idx;
      default: win_idx = lsb_idx;
    endcase
    if (int'(win_idx) == N - 1) ptr_next = '0;
    else                         ptr_next = win_idx + W'(1);
  end

  // Output register and round-robin pointer; a drain without a new accept empties the register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_valid <= 1'b0;
      result_y     <= '0;
      result_found <= 1'b0;
      result_multi <= 1'b0;
      rr_ptr       <= '0;
    end else begin
      if (accept) begin
        result_valid <= 1'b1;
        result_y     <= win_idx;
        result_found <= any_set;
        result_multi <= many_set;
        if ((bus.mode == 2'b10) && any_set) rr_ptr <= ptr_next;
      end else if (bus.out_ready) begin
        result_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_priority_encoder_rr.sv
// Scoreboard bench for priority_encoder_rr at N=64 and N=5. Expected results
// are pushed when a vector is accepted and popped when the result is taken.
module tb_priority_encoder_rr;
  typedef struct {
    logic [5:0] y;
    logic       found;
    logic       multi;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passed = 0;
  int   ptr64 = 0;
  int   ptr5 = 0;
  exp_t q64[$];
  exp_t q5[$];

  always #5 clk = ~clk;

  priority_encoder_rr_if #(.N(64)) bus64();
  priority_encoder_rr_if #(.N(5))  bus5();

  priority_encoder_rr #(.N(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));
  priority_encoder_rr #(.N(5))  dut5  (.clk(clk), .rst_n(rst_n), .bus(bus5));

  // Reference model: popcount for the flags, a rotating scan for round-robin.
  function automatic exp_t model(input logic [63:0] a, input logic [1:0] mode, input int n,
                                 input int ptr_in, output int ptr_out);
    exp_t e;
    int   cnt;
    int   pick;
    cnt = 0;
    pick = 0;
    ptr_out = ptr_in;
    for (int i = 0; i < n; i++) if (a[i]) cnt++;
    e.found = (cnt > 0);
    e.multi = (cnt > 1);
    if (cnt > 0) begin
      if (mode == 2'b01) begin
        for (int i = n - 1; i >= 0; i--) if (a[i]) begin pick = i; break; end
      end else if (mode == 2'b10) begin
        for (int k = 0; k < n; k++) if (a[(ptr_in + k) % n]) begin pick = (ptr_in + k) % n; break; end
        ptr_out = (pick + 1) % n;
      end else begin
        for (int i = 0; i < n; i++) if (a[i]) begin pick = i; break; end
      end
    end
    e.y = 6'(pick);
    return e;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus64.enable = 1'b1; bus64.in_valid = 1'b1; bus64.a = 64'h5; bus64.out_ready = 1'b0;
    bus5.enable = 1'b1;  bus5.in_valid = 1'b1;  bus5.a = 5'b00101; bus5.out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({bus64.out_valid, bus64.y, bus64.in_ready} !== {1'b0, 6'd0, 1'b0})
        $display("[TB] FAIL reset64[%0d]: out_valid=%b y=%0d in_ready=%b, expected 0/0/0",
                 c, bus64.out_valid, bus64.y, bus64.in_ready);
      else passed++;
      checks++;
      if ({bus5.out_valid, bus5.y, bus5.in_ready} !== {1'b0, 3'd0, 1'b0})
        $display("[TB] FAIL reset5[%0d]: out_valid=%b y=%0d in_ready=%b, expected 0/0/0",
                 c, bus5.out_valid, bus5.y, bus5.in_ready);
      else passed++;
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    bus64.in_valid = 1'b0;
    bus5.in_valid = 1'b0;
    ptr64 = 0;
    ptr5 = 0;
    @(negedge clk);
    checks++;
    if ({bus64.out_valid, bus64.in_ready, bus64.found, bus64.multi} !== 4'b0100)
      $display("[TB] FAIL reset_release: out_valid=%b in_ready=%b found=%b multi=%b, expected 0/1/0/0",
               bus64.out_valid, bus64.in_ready, bus64.found, bus64.multi);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_onehot_sweep();
    exp_t e;
    bus64.mode = 2'b00; bus64.out_ready = 1'b1; bus64.enable = 1'b1;
    for (int i = 0; i <= 64; i++) begin
      bus64.in_valid = (i < 64);
      bus64.a = (i < 64) ? (64'd1 << i) : 64'd0;
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (bus64.out_valid !== 1'b1)
          $display("[TB] FAIL sweep_valid[%0d]: got %b, expected 1", i, bus64.out_valid);
        else passed++;
      end
      if (bus64.out_valid === 1'b1) begin
        checks++;
        if (q64.size() == 0) $display("[TB] FAIL sweep_extra[%0d]: result with empty scoreboard", i);
        else begin
          e = q64.pop_front();
          if ({bus64.y, bus64.found, bus64.multi} !== {e.y, e.found, e.multi})
            $display("[TB] FAIL sweep_result[%0d]: y=%0d found=%b multi=%b, expected y=%0d found=%b multi=%b",
                     i, bus64.y, bus64.found, bus64.multi, e.y, e.found, e.multi);
          else passed++;
        end
      end
      if (i < 64) begin
        checks++;
        if (bus64.in_ready !== 1'b1) $display("[TB] FAIL sweep_ready[%0d]: got %b, expected 1", i, bus64.in_ready);
        else passed++;
        q64.push_back(model(bus64.a, bus64.mode, 64, ptr64, ptr64));
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (bus64.out_valid !== 1'b0 || q64.size() != 0)
      $display("[TB] FAIL sweep_drain: out_valid=%b pending=%0d, expected 0/0", bus64.out_valid, q64.size());
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_priority();
    exp_t e;
    logic [1:0] modes[2] = '{2'b00, 2'b01};
    int ys[2] = '{0, 63};
    bus64.out_ready = 1'b1;
    for (int i = 0; i <= 2; i++) begin
      bus64.in_valid = (i < 2);
      bus64.a = 64'h8000_0000_0000_0011;
      bus64.mode = (i < 2) ? modes[i] : 2'b00;
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (bus64.out_valid !== 1'b1 || q64.size() == 0)
          $display("[TB] FAIL prio_valid[%0d]: out_valid=%b pending=%0d, expected 1 with a pending result",
                   i, bus64.out_valid, q64.size());
        else begin
          e = q64.pop_front();
          if ({bus64.y, bus64.found, bus64.multi} !== {e.y, e.found, e.multi})
            $display("[TB] FAIL prio_result[%0d]: y=%0d found=%b multi=%b, expected y=%0d found=%b multi=%b",
                     i, bus64.y, bus64.found, bus64.multi, e.y, e.found, e.multi);
          else passed++;
        end
      end
      if (i < 2) begin
        e.y = 6'(ys[i]); e.found = 1'b1; e.multi = 1'b1;
        q64.push_back(e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    exp_t dummy;
    logic [63:0] av[6] = '{64'h8000_0000_0000_0011, 64'h8000_0000_0000_0011, 64'h8000_0000_0000_0011,
                           64'h8000_0000_0000_0011, 64'h0, 64'h11};
    int   ys[6] = '{0, 4, 63, 0, 0, 4};
    logic fs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    bus64.out_ready = 1'b1;
    bus64.mode = 2'b10;
    for (int i = 0; i <= 6; i++) begin
      bus64.in_valid = (i < 6);
      bus64.a = (i < 6) ? av[i] : 64'h0;
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (bus64.out_valid !== 1'b1 || q64.size() == 0)
          $display("[TB] FAIL rr_valid[%0d]: out_valid=%b pending=%0d, expected 1 with a pending result",
                   i, bus64.out_valid, q64.size());
        else begin
          e = q64.pop_front();
          if ({bus64.y, bus64.found, bus64.multi} !== {e.y, e.found, e.multi})
            $display("[TB] FAIL rr_result[%0d]: y=%0d found=%b multi=%b, expected y=%0d found=%b multi=%b",
                     i, bus64.y, bus64.found, bus64.multi, e.y, e.found, e.multi);
          else passed++;
        end
      end
      if (i < 6) begin
        dummy = model(av[i], 2'b10, 64, ptr64, ptr64);
        e.y = 6'(ys[i]); e.found = fs[i]; e.multi = fs[i];
        q64.push_back(e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    bus64.in_valid = 1'b1; bus64.a = 64'd1 << 40; bus64.mode = 2'b01; bus64.out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus64.in_ready !== 1'b1) $display("[TB] FAIL bp_first_ready: got %b, expected 1", bus64.in_ready);
    else passed++;
    q64.push_back(model(bus64.a, bus64.mode, 64, ptr64, ptr64));
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      bus64.a = 64'h3; bus64.mode = 2'b10;
      @(negedge clk);
      checks++;
      if ({bus64.out_valid, bus64.in_ready, bus64.y} !== {1'b1, 1'b0, 6'd40})
        $display("[TB] FAIL bp_hold[%0d]: out_valid=%b in_ready=%b y=%0d, expected 1/0/40",
                 c, bus64.out_valid, bus64.in_ready, bus64.y);
      else passed++;
      @(posedge clk); #1;
    end
    bus64.out_ready = 1'b1; bus64.mode = 2'b00;
    for (int c = 0; c < 2; c++) begin
      bus64.in_valid = (c == 0);
      @(negedge clk);
      checks++;
      if (bus64.out_valid !== 1'b1 || q64.size() == 0)
        $display("[TB] FAIL bp_valid[%0d]: out_valid=%b pending=%0d, expected 1 with a pending result",
                 c, bus64.out_valid, q64.size());
      else begin
        e = q64.pop_front();
        if ({bus64.y, bus64.found, bus64.multi} !== {e.y, e.found, e.multi})
          $display("[TB] FAIL bp_result[%0d]: y=%0d found=%b multi=%b, expected y=%0d found=%b multi=%b",
                   c, bus64.y, bus64.found, bus64.multi, e.y, e.found, e.multi);
        else passed++;
      end
      if (c == 0) begin
        checks++;
        if (bus64.in_ready !== 1'b1) $display("[TB] FAIL bp_same_edge_ready: got %b, expected 1", bus64.in_ready);
        else passed++;
        q64.push_back(model(bus64.a, bus64.mode, 64, ptr64, ptr64));
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (bus64.out_valid !== 1'b0) $display("[TB] FAIL bp_empty: out_valid=%b, expected 0", bus64.out_valid);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_small_n();
    exp_t e;
    bus5.enable = 1'b1; bus5.mode = 2'b10; bus5.out_ready = 1'b1;
    for (int i = 0; i <= 3; i++) begin
      bus5.in_valid = (i < 3);
      bus5.a = 5'b10001;
      @(negedge clk);
      if (bus5.out_valid === 1'b1) begin
        checks++;
        if (q5.size() == 0) $display("[TB] FAIL n5_extra[%0d]: result with empty scoreboard", i);
        else begin
          e = q5.pop_front();
          if ({bus5.y, bus5.found, bus5.multi} !== {e.y[2:0], e.found, e.multi})
            $display("[TB] FAIL n5_result[%0d]: y=%0d found=%b multi=%b, expected y=%0d found=%b multi=%b",
                     i, bus5.y, bus5.found, bus5.multi, e.y, e.found, e.multi);
          else passed++;
        end
        checks++;
        if (!(bus5.y < 3'd5)) $display("[TB] FAIL n5_range[%0d]: y=%0d, expected below 5", i, bus5.y);
        else passed++;
      end
      if (i < 3) q5.push_back(model(64'(bus5.a), bus5.mode, 5, ptr5, ptr5));
      @(posedge clk); #1;
    end
    // A held result must still drain while enable is low.
    bus5.in_valid = 1'b1; bus5.a = 5'b00110; bus5.mode = 2'b00; bus5.out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus5.in_ready !== 1'b1 || q5.size() != 0)
      $display("[TB] FAIL n5_en_ready: in_ready=%b pending=%0d, expected 1/0", bus5.in_ready, q5.size());
    else passed++;
    q5.push_back(model(64'(bus5.a), bus5.mode, 5, ptr5, ptr5));
    @(posedge clk); #1;
    bus5.enable = 1'b0; bus5.a = 5'b11111;
    @(negedge clk);
    checks++;
    if ({bus5.in_ready, bus5.out_valid} !== 2'b01)
      $display("[TB] FAIL n5_disabled: in_ready=%b out_valid=%b, expected 0/1", bus5.in_ready, bus5.out_valid);
    else passed++;
    @(posedge clk); #1;
    bus5.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus5.in_ready !== 1'b0 || bus5.out_valid !== 1'b1 || q5.size() == 0)
      $display("[TB] FAIL n5_drain: in_ready=%b out_valid=%b pending=%0d, expected 0/1 with a pending result",
               bus5.in_ready, bus5.out_valid, q5.size());
    else begin
      e = q5.pop_front();
      if ({bus5.y, bus5.found, bus5.multi} !== {e.y[2:0], e.found, e.multi})
        $display("[TB] FAIL n5_drain_result: y=%0d found=%b multi=%b, expected y=%0d found=%b multi=%b",
                 bus5.y, bus5.found, bus5.multi, e.y, e.found, e.multi);
      else passed++;
    end
    @(posedge clk); #1;
    bus5.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus5.out_valid !== 1'b0) $display("[TB] FAIL n5_empty: out_valid=%b, expected 0", bus5.out_valid);
    else passed++;
    @(posedge clk); #1;
  endtask

  initial begin
    bus64.enable = 1'b1; bus64.in_valid = 1'b0; bus64.a = '0; bus64.mode = 2'b00; bus64.out_ready = 1'b0;
    bus5.enable = 1'b1;  bus5.in_valid = 1'b0;  bus5.a = '0;  bus5.mode = 2'b00;  bus5.out_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_onehot_sweep();
    test_priority();
    test_round_robin();
    test_backpressure();
    test_small_n();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
